// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, overflow trap, multi-cycle shift-add multiplier, EX pipeline register
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] id_pc,
  input  logic        id_en,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_alu_in_0,
  input  logic [31:0] id_alu_in_1,
  input  logic        id_br_flag,
  input  logic [1:0]  id_mem_op,
  input  logic [31:0] id_mem_wr_data,
  input  logic [1:0]  id_ctrl_op,
  input  logic [4:0]  id_dst_addr,
  input  logic        id_gpr_we_,
  input  logic [2:0]  id_exp_code,
  output logic [31:0] ex_fwd_data,
  output logic        ex_busy,
  output logic [29:0] ex_pc,
  output logic        ex_en,
  output logic        ex_br_flag,
  output logic [1:0]  ex_mem_op,
  output logic [31:0] ex_mem_wr_data,
  output logic [1:0]  ex_ctrl_op,
  output logic [4:0]  ex_dst_addr,
  output logic        ex_gpr_we_,
  output logic [2:0]  ex_exp_code,
  output logic [31:0] ex_out
);

  localparam logic [3:0] OP_AND = 4'd1, OP_OR = 4'd2, OP_XOR = 4'd3, OP_ADDS = 4'd4,
                         OP_ADDU = 4'd5, OP_SUBS = 4'd6, OP_SUBU = 4'd7, OP_SHRL = 4'd8,
                         OP_SHLL = 4'd9, OP_MUL = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] prod;

  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] alu_res;
  logic        ovf;
  logic        is_mul;

  assign sum    = id_alu_in_0 + id_alu_in_1;
  assign diff   = id_alu_in_0 - id_alu_in_1;
  assign is_mul = (id_alu_op == OP_MUL);

  always_comb begin
    alu_res = 32'd0;
    ovf     = 1'b0;
    case (id_alu_op)
      OP_AND:  alu_res = id_alu_in_0 & id_alu_in_1;
      OP_OR:   alu_res = id_alu_in_0 | id_alu_in_1;
      OP_XOR:  alu_res = id_alu_in_0 ^ id_alu_in_1;
      OP_ADDS: begin
        alu_res = sum;
        ovf     = (id_alu_in_0[31] == id_alu_in_1[31]) && (sum[31] != id_alu_in_0[31]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUBS: begin
        alu_res = diff;
        ovf     = (id_alu_in_0[31] != id_alu_in_1[31]) && (diff[31] != id_alu_in_0[31]);
      end
      OP_SUBU: alu_res = diff;
      OP_SHRL: alu_res = id_alu_in_0 >> id_alu_in_1[4:0];
      OP_SHLL: alu_res = id_alu_in_0 << id_alu_in_1[4:0];
      OP_MUL:  alu_res = (state == DONE) ? prod : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  assign ex_fwd_data = alu_res;
  assign ex_busy     = ((state == IDLE) && id_en && is_mul) || (state == BUSY);

  // Multiplier sequencer; the counter keeps running under stall so latency is fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      prod   <= 32'd0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (id_en && is_mul) begin
            mcand  <= id_alu_in_0;
            mplier <= id_alu_in_1;
            prod   <= 32'd0;
            cnt    <= 5'd0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE: begin
          if (!stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EX pipeline register: bubble on rst/flush/busy, hold on stall.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && ex_busy)) begin
      ex_pc          <= 30'd0;
      ex_en          <= 1'b0;
      ex_br_flag     <= 1'b0;
      ex_mem_op      <= 2'd0;
      ex_mem_wr_data <= 32'd0;
      ex_ctrl_op     <= 2'd0;
      ex_dst_addr    <= 5'd0;
      ex_gpr_we_     <= 1'b1;
      ex_exp_code    <= 3'd0;
      ex_out         <= 32'd0;
    end else if (!stall) begin
      ex_pc          <= id_pc;
      ex_en          <= id_en;
      ex_br_flag     <= id_br_flag;
      ex_mem_wr_data <= id_mem_wr_data;
      ex_ctrl_op     <= id_ctrl_op;
      ex_dst_addr    <= id_dst_addr;
      ex_out         <= alu_res;
      if (ovf && (id_exp_code == 3'd0)) begin
        ex_exp_code <= 3'd3;
        ex_gpr_we_  <= 1'b1;
        ex_mem_op   <= 2'd0;
      end else begin
        ex_exp_code <= id_exp_code;
        ex_gpr_we_  <= id_gpr_we_;
        ex_mem_op   <= id_mem_op;
      end
    end
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters: none; all widths are fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  1  pipeline stall; EX register holds.
REQ-005 flush  in  1  pipeline flush; EX register loads bubble.
REQ-006 id_pc  in  30  word address of instruction in ID register.
REQ-007 id_en  in  1  ID register valid.
REQ-008 id_alu_op  in  4  0 NOP, 1 AND, 2 OR, 3 XOR, 4 ADDS, 5 ADDU, 6 SUBS, 7 SUBU, 8 SHRL, 9 SHLL, 10 MUL, 11-15 NOP.
REQ-009 id_alu_in_0 / id_alu_in_1  in  32 each  ALU operands.
REQ-010 id_br_flag, id_mem_op(2), id_mem_wr_data(32), id_ctrl_op(2)  in  passthrough fields.
REQ-011 id_dst_addr  in  5, id_gpr_we_  in  1 (active-low), id_exp_code  in  3  destination, write enable, exception.
REQ-012 ex_fwd_data  out  32  combinational result of the ID-register instruction, forwarded to the decoder.
REQ-013 ex_busy  out  1  multiplier stall request to pipeline control.
REQ-014 ex_pc(30), ex_en(1), ex_br_flag, ex_mem_op(2), ex_mem_wr_data(32), ex_ctrl_op(2), ex_dst_addr(5), ex_gpr_we_, ex_exp_code(3), ex_out(32)  out  registered EX outputs.

Function
REQ-015 Logic ops are bitwise; ADDS/ADDU/SUBS/SUBU are 32-bit modulo.
REQ-016 SHRL/SHLL are logical shifts of in_0 by in_1[4:0]; in_1[31:5] is ignored.
REQ-017 NOP and codes 11-15 yield result 0.
REQ-018 Signed overflow flag: ADDS when both operand signs match and result sign differs; SUBS when signs differ and result sign differs from in_0.
REQ-019 If overflow and id_exp_code==0, the EX register captures exp_code 3, gpr_we_=1 and mem_op=0; otherwise id_exp_code passes unchanged.
REQ-020 MUL: unsigned shift-add, low 32 bits of product; FSM states IDLE, BUSY, DONE.
REQ-021 IDLE -> BUSY when id_en=1, op==MUL, flush=0; operands latched; 5-bit counter cleared.
REQ-022 BUSY: one partial-product step per cycle; after 32 cycles -> DONE.
REQ-023 DONE: ex_fwd_data = product; -> IDLE when stall=0, else hold DONE.
REQ-024 ex_busy = (IDLE and id_en and op==MUL) or BUSY; it is 0 in DONE.
REQ-025 MUL latency: op present in ID at cycle T; ex_busy is high T..T+32; result reaches ex_out at the end of T+33.
REQ-026 In IDLE or BUSY with a MUL pending, ex_fwd_data = 0.
REQ-027 EX register update priority: rst, then flush (bubble), then stall (hold), then ex_busy=1 (bubble), otherwise load.
REQ-028 Bubble: ex_en=0, gpr_we_=1, mem_op=0, ctrl_op=0, br_flag=0, exp_code=0, ex_out=0, all other fields 0.
REQ-029 Load: fields come from the ID inputs; ex_out = ex_fwd_data; ex_en = id_en.
REQ-030 flush in any state forces FSM to IDLE, aborting any multiply; a MUL is not restarted in that cycle.
REQ-031 stall during BUSY does not pause the counter.
REQ-032 When id_en=0, FSM stays in IDLE and ex_busy=0, whatever the value of id_alu_op.

Reset
REQ-033 On rst, FSM = IDLE, counter = 0, ex_busy = 0, all EX register outputs take the bubble values of REQ-028, ex_pc = 0.
REQ-034 rst mid-multiply aborts it; the first cycle after reset behaves as IDLE.

Verification
REQ-035 ADDU 0xFFFFFFFF + 1, id_en=1 -> ex_out=0 next cycle, ex_exp_code=0, ex_gpr_we_ = id_gpr_we_.
REQ-036 ADDS 0x7FFFFFFF + 1, id_exp_code=0 -> ex_exp_code=3, ex_gpr_we_=1, ex_mem_op=0.
REQ-037 SHLL in_0=1, in_1=0x21 -> ex_fwd_data=2; SHRL 0x80000000 by 31 -> 1.
REQ-038 MUL 0x0001_0003 x 0x0000_0005 at cycle T -> ex_busy high 33 cycles with bubbles in EX; ex_out=0x0005_000F at T+34; ex_en=1.
REQ-039 flush during BUSY cycle 10 -> FSM IDLE, ex_busy=0 next cycle, EX shows bubble; rst mid-MUL -> outputs equal reset values.
